// File: rtl/mips_mem_access_ctrl.sv
// Byte/half/word load-store initiator over a word-indexed data memory; big-endian lanes, RMW for sub-word stores.
// Latency accept->resp_valid: error 1, load 2, word store 2, sub-word store 3. req_ready only in IDLE, resp has no backpressure.
// MIPS_MEM_ACCESS_ALIGN_CHECK_EN: misaligned half/word requests error out instead of being aligned down.
module mips_mem_access_ctrl #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] write_data,
    output logic        sig_mem_read,
    output logic        sig_mem_write,
    input  logic [31:0] read_data
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wr_word;
    logic [31:0] rdata_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic        write_q;
    logic        err_q;

    logic [31:0] acc_addr;
    logic        acc_err;

    // Byte lane b sits at bits [31-8b -: 8]; shifting by 8*(3-b) == {~b,3'b0} brings it to [7:0].
    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] a,
                                                 input logic [1:0] size, input logic sgn);
        logic [31:0] sh;
        logic [15:0] h;
        sh = word >> {~a, 3'b000};
        h  = a[1] ? word[15:0] : word[31:16];
        case (size)
            2'b00:   lane_extract = sgn ? {{24{sh[7]}}, sh[7:0]} : {24'd0, sh[7:0]};
            2'b01:   lane_extract = sgn ? {{16{h[15]}}, h} : {16'd0, h};
            default: lane_extract = word;
        endcase
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [1:0] a,
                                               input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] mask;
        logic [31:0] data;
        case (size)
            2'b00: begin
                mask = 32'h0000_00FF << {~a, 3'b000};
                data = {24'd0, wdata[7:0]} << {~a, 3'b000};
            end
            2'b01: begin
                mask = a[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
                data = a[1] ? {16'd0, wdata[15:0]} : {wdata[15:0], 16'd0};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                data = wdata;
            end
        endcase
        lane_merge = (word & ~mask) | data;
    endfunction

    always_comb begin
        acc_addr = req_addr;
        acc_err  = (req_size == 2'b11) || ({2'b00, req_addr[31:2]} >= MEM_WORDS_W);
`ifdef MIPS_MEM_ACCESS_ALIGN_CHECK_EN
        if ((req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00))
            acc_err = 1'b1;
`else
        if (req_size == 2'b01)
            acc_addr[0] = 1'b0;
        else if (req_size == 2'b10)
            acc_addr[1:0] = 2'b00;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr_q   <= '0;
            wr_word  <= '0;
            rdata_q  <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    addr_q   <= acc_addr;
                    size_q   <= req_size;
                    signed_q <= req_signed;
                    write_q  <= req_write;
                    wr_word  <= req_wdata;
                    rdata_q  <= '0;
                    err_q    <= acc_err;
                    if (acc_err)
                        state <= RESP;
                    else if (req_write && req_size == 2'b10)
                        state <= WR;
                    else
                        state <= RD;
                end
                RD: begin
                    if (write_q) begin
                        wr_word <= lane_merge(read_data, addr_q[1:0], size_q, wr_word);
                        state   <= WR;
                    end else begin
                        rdata_q <= lane_extract(read_data, addr_q[1:0], size_q, signed_q);
                        state   <= RESP;
                    end
                end
                WR:      state <= RESP;
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready     = (state == IDLE);
    assign sig_mem_read  = (state == RD);
    assign sig_mem_write = (state == WR);
    assign resp_valid    = (state == RESP);
    assign resp_err      = (state == RESP) & err_q;
    assign resp_rdata    = (state == RESP) ? rdata_q : 32'd0;
    assign mem_address   = {2'b00, addr_q[31:2]};
    assign write_data    = wr_word;
endmodule

// File: tb/tb_mips_mem_access_ctrl.sv
// Directed bench for mips_mem_access_ctrl with a behavioural async-read data memory.
module tb_mips_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] write_data;
    logic        sig_mem_read;
    logic        sig_mem_write;
    logic [31:0] read_data;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    assign read_data = mem[mem_address[7:0]];
    always @(posedge clk) if (sig_mem_write) mem[mem_address[7:0]] <= write_data;

    mips_mem_access_ctrl #(.MEM_WORDS(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_address(mem_address), .write_data(write_data),
        .sig_mem_read(sig_mem_read), .sig_mem_write(sig_mem_write), .read_data(read_data)
    );

    int          lat, nrd, nwr, both;
    logic [31:0] rd, wdat, maddr;
    logic        er;

    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd);
        bit done = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL req_ready_idle got %b want 1", req_ready); end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; nrd = 0; nwr = 0; both = 0; rd = 'x; er = 1'bx; wdat = 'x; maddr = 'x;
        for (int i = 1; i <= 10 && !done; i++) begin
            @(negedge clk);
            if (sig_mem_read) begin nrd++; maddr = mem_address; end
            if (sig_mem_write) begin nwr++; wdat = write_data; maddr = mem_address; end
            if (sig_mem_read && sig_mem_write) both++;
            if (resp_valid) begin lat = i; rd = resp_rdata; er = resp_err; done = 1; end
        end
        checks++;
        if (!done) begin errors++; $display("FAIL resp_timeout got none want resp_valid within 10 cycles"); end
        if (both != 0) begin errors++; $display("FAIL strobe_overlap got %0d cycles want 0", both); end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, sig_mem_read, sig_mem_write, resp_err} !== 5'b10000) begin
            errors++; $display("FAIL reset_ctrl got %b want 10000",
                               {req_ready, resp_valid, sig_mem_read, sig_mem_write, resp_err});
        end
        checks++;
        if (mem_address !== 32'd0 || write_data !== 32'd0 || resp_rdata !== 32'd0) begin
            errors++; $display("FAIL reset_data got addr=%h wd=%h rd=%h want 0", mem_address, write_data, resp_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_release got rdy=%b vld=%b want 1/0", req_ready, resp_valid);
        end
    endtask

    task automatic test_word;
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678);
        checks++;
        if (lat != 2 || nwr != 1 || nrd != 0 || er !== 1'b0) begin
            errors++; $display("FAIL sw_timing got lat=%0d wr=%0d rd=%0d err=%b want 2/1/0/0", lat, nwr, nrd, er);
        end
        checks++;
        if (maddr !== 32'd4 || wdat !== 32'h1234_5678) begin
            errors++; $display("FAIL sw_data got addr=%h wd=%h want 4/12345678", maddr, wdat);
        end
        do_req(1'b0, 2'b10, 1'b1, 32'h10, 32'h0);
        checks++;
        if (lat != 2 || nrd != 1 || nwr != 0 || rd !== 32'h1234_5678 || er !== 1'b0) begin
            errors++; $display("FAIL lw got lat=%0d rd=%0d data=%h err=%b want 2/1/12345678/0", lat, nrd, rd, er);
        end
    endtask

    task automatic test_byte;
        do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FFAB);
        checks++;
        if (lat != 3 || nrd != 1 || nwr != 1 || wdat !== 32'h12AB_5678 || rd !== 32'd0) begin
            errors++; $display("FAIL sb got lat=%0d rd=%0d wr=%0d wd=%h rdata=%h want 3/1/1/12ab5678/0",
                               lat, nrd, nwr, wdat, rd);
        end
        do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
        checks++;
        if (rd !== 32'hFFFF_FFAB || lat != 2) begin
            errors++; $display("FAIL lb got %h lat=%0d want ffffffab lat=2", rd, lat);
        end
        do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
        checks++;
        if (rd !== 32'h0000_00AB) begin errors++; $display("FAIL lbu got %h want 000000ab", rd); end
        do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        checks++;
        if (rd !== 32'h0000_0078) begin errors++; $display("FAIL lb_lane3 got %h want 00000078", rd); end
    endtask

    task automatic test_half;
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_F00D);
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        checks++;
        if (rd !== 32'hFFFF_F00D) begin errors++; $display("FAIL lh got %h want fffff00d", rd); end
        do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
        checks++;
        if (rd !== 32'h0000_1234) begin errors++; $display("FAIL lhu got %h want 00001234", rd); end
        do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_BEEF);
        checks++;
        if (wdat !== 32'h1234_BEEF || lat != 3) begin
            errors++; $display("FAIL sh got wd=%h lat=%0d want 1234beef lat=3", wdat, lat);
        end
    endtask

    task automatic test_align_size;
        do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
`ifdef MIPS_MEM_ACCESS_ALIGN_CHECK_EN
        checks++;
        if (er !== 1'b1 || lat != 1 || nrd != 0 || nwr != 0) begin
            errors++; $display("FAIL lw_misalign got err=%b lat=%0d rd=%0d wr=%0d want 1/1/0/0", er, lat, nrd, nwr);
        end
`else
        checks++;
        if (er !== 1'b0 || lat != 2 || maddr !== 32'd4 || rd !== 32'h1234_BEEF) begin
            errors++; $display("FAIL lw_aligndown got err=%b lat=%0d addr=%h data=%h want 0/2/4/1234beef",
                               er, lat, maddr, rd);
        end
`endif
        do_req(1'b1, 2'b11, 1'b0, 32'h10, 32'hDEAD_BEEF);
        checks++;
        if (er !== 1'b1 || lat != 1 || nrd != 0 || nwr != 0 || rd !== 32'd0) begin
            errors++; $display("FAIL bad_size got err=%b lat=%0d rd=%0d wr=%0d data=%h want 1/1/0/0/0",
                               er, lat, nrd, nwr, rd);
        end
    endtask

    task automatic test_range;
        do_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
        checks++;
        if (er !== 1'b1 || lat != 1 || nrd != 0 || nwr != 0) begin
            errors++; $display("FAIL range_over got err=%b lat=%0d rd=%0d wr=%0d want 1/1/0/0", er, lat, nrd, nwr);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0);
        checks++;
        if (er !== 1'b0 || maddr !== 32'd255 || rd !== 32'd0) begin
            errors++; $display("FAIL range_last got err=%b addr=%0d data=%h want 0/255/0", er, maddr, rd);
        end
    endtask

    task automatic test_reset_mid;
        int nwr_seen = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'h10; req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (sig_mem_read !== 1'b1) begin errors++; $display("FAIL mid_rd got %b want 1", sig_mem_read); end
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (sig_mem_write) nwr_seen++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (sig_mem_write) nwr_seen++;
        end
        checks++;
        if (nwr_seen != 0 || req_ready !== 1'b1 || sig_mem_read !== 1'b0) begin
            errors++; $display("FAIL mid_reset got writes=%0d rdy=%b rd=%b want 0/1/0", nwr_seen, req_ready, sig_mem_read);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        checks++;
        if (rd !== 32'h1234_BEEF) begin errors++; $display("FAIL mid_reset_mem got %h want 1234beef", rd); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        test_reset;
        test_word;
        test_byte;
        test_half;
        test_align_size;
        test_range;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
